// File: rtl/relogio_pkg.sv
// Shared types and BCD limits for the clock time-set controller.
package relogio_pkg;

   typedef enum logic [1:0] {RUN, SET_H, SET_M, COMMIT} ajuste_state_t;

   localparam logic [1:0] HOUR_MAX_MSD = 2'd2;
   localparam logic [3:0] HOUR_MAX_LSD = 4'd3;
   localparam logic [2:0] MIN_MAX_MSD  = 3'd5;
   localparam logic [3:0] BCD_MAX      = 4'd9;

   // True when the BCD pair is a legal hour 00..23
   function automatic logic hora_valida(input logic [1:0] msd, input logic [3:0] lsd);
      return ((msd < HOUR_MAX_MSD) && (lsd <= BCD_MAX)) ||
             ((msd == HOUR_MAX_MSD) && (lsd <= HOUR_MAX_LSD));
   endfunction

   // True when the BCD pair is a legal minute 00..59
   function automatic logic minuto_valido(input logic [2:0] msd, input logic [3:0] lsd);
      return (msd <= MIN_MAX_MSD) && (lsd <= BCD_MAX);
   endfunction

endpackage

// File: rtl/botao_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability debounce and a
// single-cycle pulse on each accepted press.
module botao_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
   input  logic clock,
   input  logic reset,
   input  logic btn,
   output logic pulse
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

   logic            sync1_q, sync2_q;
   logic            stable_q, stable_d;
   logic            stable_dly_q;
   logic            pulse_q;
   logic [CntW-1:0] cnt_q, cnt_d;

   // Count consecutive samples that disagree with the accepted level
   always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      if (sync2_q != stable_q) begin
         if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   // Synchronizer, debounce state and rising-edge pulse registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         stable_q     <= 1'b0;
         stable_dly_q <= 1'b0;
         cnt_q        <= '0;
         pulse_q      <= 1'b0;
      end else begin
         sync1_q      <= btn;
         sync2_q      <= sync1_q;
         stable_q     <= stable_d;
         stable_dly_q <= stable_q;
         cnt_q        <= cnt_d;
         pulse_q      <= stable_q & ~stable_dly_q;
      end
   end

   assign pulse = pulse_q;

endmodule

// File: rtl/relogio_ajuste.sv
// Time-set controller: gates the 1 Hz tick, edits hours/minutes in BCD,
// issues a one-cycle parallel load and blinks the field under edit.
module relogio_ajuste
   import relogio_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 50_000_000 / 100,
   parameter int unsigned BLINK_CYCLES    = 50_000_000 / 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       tick_in,
   input  logic [1:0] cur_h_msd,
   input  logic [3:0] cur_h_lsd,
   input  logic [2:0] cur_m_msd,
   input  logic [3:0] cur_m_lsd,
   output logic       tick_out,
   output logic       load,
   output logic [1:0] load_h_msd,
   output logic [3:0] load_h_lsd,
   output logic [2:0] load_m_msd,
   output logic [3:0] load_m_lsd,
   output logic       blank_h,
   output logic       blank_m
);

   localparam int unsigned BlinkW = $clog2(BLINK_CYCLES + 1);

   ajuste_state_t     state_q, state_d;
   logic [1:0]        h_msd_q, h_msd_d;
   logic [3:0]        h_lsd_q, h_lsd_d;
   logic [2:0]        m_msd_q, m_msd_d;
   logic [3:0]        m_lsd_q, m_lsd_d;
   logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
   logic              blink_q, blink_d;
   logic              mode_p, inc_p;
   logic              editing;

   botao_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_mode (
      .clock (clock),
      .reset (reset),
      .btn   (btn_mode),
      .pulse (mode_p)
   );

   botao_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_inc (
      .clock (clock),
      .reset (reset),
      .btn   (btn_inc),
      .pulse (inc_p)
   );

   // State and edit/blink registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= RUN;
         h_msd_q     <= '0;
         h_lsd_q     <= '0;
         m_msd_q     <= '0;
         m_lsd_q     <= '0;
         blink_cnt_q <= '0;
         blink_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         h_msd_q     <= h_msd_d;
         h_lsd_q     <= h_lsd_d;
         m_msd_q     <= m_msd_d;
         m_lsd_q     <= m_lsd_d;
         blink_cnt_q <= blink_cnt_d;
         blink_q     <= blink_d;
      end
   end

   // Next state: mode steps through the edit fields, COMMIT lasts one cycle
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:     if (mode_p) state_d = SET_H;
         SET_H:   if (mode_p) state_d = SET_M;
         SET_M:   if (mode_p) state_d = COMMIT;
         COMMIT:  state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // Edit registers: capture on entry, BCD increment; mode press beats inc press
   always_comb begin
      h_msd_d = h_msd_q;
      h_lsd_d = h_lsd_q;
      m_msd_d = m_msd_q;
      m_lsd_d = m_lsd_q;
      if (state_q == RUN && mode_p) begin
         // Out-of-range running values are replaced so the edit regs stay legal
         if (hora_valida(cur_h_msd, cur_h_lsd)) begin
            h_msd_d = cur_h_msd;
            h_lsd_d = cur_h_lsd;
         end else begin
            h_msd_d = '0;
            h_lsd_d = '0;
         end
         if (minuto_valido(cur_m_msd, cur_m_lsd)) begin
            m_msd_d = cur_m_msd;
            m_lsd_d = cur_m_lsd;
         end else begin
            m_msd_d = '0;
            m_lsd_d = '0;
         end
      end else if (state_q == SET_H && !mode_p && inc_p) begin
         if (h_msd_q == HOUR_MAX_MSD && h_lsd_q == HOUR_MAX_LSD) begin
            h_msd_d = '0;
            h_lsd_d = '0;
         end else if (h_lsd_q == BCD_MAX) begin
            h_lsd_d = '0;
            h_msd_d = h_msd_q + 2'd1;
         end else begin
            h_lsd_d = h_lsd_q + 4'd1;
         end
      end else if (state_q == SET_M && !mode_p && inc_p) begin
         if (m_lsd_q == BCD_MAX) begin
            m_lsd_d = '0;
            m_msd_d = (m_msd_q == MIN_MAX_MSD) ? 3'd0 : m_msd_q + 3'd1;
         end else begin
            m_lsd_d = m_lsd_q + 4'd1;
         end
      end
   end

   assign editing = (state_q == SET_H) || (state_q == SET_M);

   // Blink phase: restarts visible on entry to an edit field, free-runs while editing
   always_comb begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
      if (state_d != state_q && (state_d == SET_H || state_d == SET_M)) begin
         blink_cnt_d = '0;
         blink_d     = 1'b0;
      end else if (editing) begin
         if (blink_cnt_q == BlinkW'(BLINK_CYCLES - 1)) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BlinkW'(1);
            blink_d     = blink_q;
         end
      end
   end

   // Outputs decoded from the registered state
   always_comb begin
      tick_out = (state_q == RUN) ? tick_in : 1'b0;
      load     = (state_q == COMMIT);
      blank_h  = (state_q == SET_H) && blink_q;
      blank_m  = (state_q == SET_M) && blink_q;
   end

   assign load_h_msd = h_msd_q;
   assign load_h_lsd = h_lsd_q;
   assign load_m_msd = m_msd_q;
   assign load_m_lsd = m_lsd_q;

endmodule
